clkdiv_multi: RTL and testbench
===============================

Name: clkdiv_multi

Overview:
- Multi-channel programmable clock/tick generator; successor to the single-channel half-period divider.
- Each channel has an independent full period, duty (high time) and enable, plus a one-cycle tick strobe at the start of each period.
- New settings take effect only at period boundaries (glitch-free reprogramming); a global sync input re-phases all channels.
- Feeds peripheral timing (UART baud, LED/PWM, timers) from the core clock.

Parameters:
- NCH, 4, number of independent channels (>=1).
- WIDTH, 25, width of period/high counters and settings.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  NCH  per-channel enable; bit i controls channel i.
- period  in  NCH*WIDTH  channel i period in clk cycles at bits [i*WIDTH +: WIDTH].
- high  in  NCH*WIDTH  channel i high time in clk cycles, same packing as period.
- sync  in  1  when high, all enabled channels restart their period on the next edge.
- out  out  NCH  divided clock, registered, glitch-free.
- tick  out  NCH  one-cycle pulse on the first cycle of each period.

Behaviour:
- Per-channel state: cnt[WIDTH], P_s[WIDTH], H_s[WIDTH] (shadow settings), running, out, tick. All outputs are registered; there is no combinational input-to-output path.
- Reset (async): cnt=0, P_s=0, H_s=0, running=0, out=0, tick=0 for all channels.
- Each clk edge, per channel, evaluate in priority order:
  - en=0: running<=0, cnt<=0, out<=0, tick<=0. Shadows are unchanged.
  - en=1 and (sync=1 or running=0 or cnt==P_s-1): start a new period. Load P_s<=period and H_s<=high, then:
    - if period<2: cnt<=0, running<=0, out<=0, tick<=0. The channel is idle and retries the load every cycle.
    - otherwise: cnt<=0, running<=1, tick<=1, out<=(high!=0).
  - otherwise: cnt<=cnt+1, tick<=0, out<=(cnt+1 < H_s).
- Result: out is high for cnt in [0, H_s) and low for cnt in [H_s, P_s). Period is exactly P_s cycles. tick is high when cnt==0 after each load.
- Duty boundaries:
  - H_s=0: out constant 0, ticks continue.
  - H_s>=P_s: out constant 1, ticks continue.
- Latency: after en rises with a valid period, out and tick are valid on the 1st edge; period length is counted from that edge.
- Reprogramming: changes to period/high while running are ignored until the edge at cnt==P_s-1, so the current period always completes with its old values.
- sync overrides an in-progress period (truncates it) and reloads the shadows. Channels with identical settings that see the same sync edge stay phase-aligned indefinitely.
- Simultaneous sync and period end are treated as a single restart, with no double tick.
- Arithmetic: cnt < P_s always holds while running, so cnt+1 fits in WIDTH bits. P_s-1 is evaluated only when running (P_s>=2). Comparisons are unsigned.
- Legacy equivalence: the old divider with value d corresponds to period=2d, high=d, except that this block starts with out high.
- Reset mid-operation forces the reset values immediately. Operation resumes on the first edge after rst deasserts.

Decomposition:
- Package clkdiv_pkg: typedef of a per-channel config struct (period, high) parameterised via WIDTH localparam default. Also holds constant MIN_PERIOD=2.
- Sub-module clkdiv_chan: one channel's state and logic, with ports clk, rst, en, sync, period, high, out, tick.
- clkdiv_multi: a generate loop instantiating NCH copies of clkdiv_chan and slicing the packed buses.

Test Plan:
- Ch0 en=1, period=4, high=2 → out 1,1,0,0 repeating from the first edge; tick at cycles 0,4,8,…
- Ch1 period=5, high=0 → out stays 0, tick every 5 cycles. Change to high=7 → out stays 1, tick unchanged.
- Ch0 running period=4; change period=6, high=3 at cnt=1 → current period finishes 4 cycles long, next period is 6 (out 1,1,1,0,0,0), with no runt pulse.
- Ch0 period=4 and ch1 period=4 enabled 2 cycles apart; pulse sync → both tick on the same edge and stay aligned.
- period=1 or 0 with en=1 → out=0 and tick=0 permanently. Set period=3, high=1 → ticks start on the next edge.
- Assert rst mid-period (cnt=2), and separately drop en → out=0, tick=0 immediately/next edge. On re-enable the channel restarts at cnt=0 with tick=1.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock/tick generator.
package clkdiv_pkg;

  localparam int unsigned CFG_WIDTH  = 25;
  localparam int unsigned MIN_PERIOD = 2;

  typedef struct packed {
    logic [CFG_WIDTH-1:0] period;
    logic [CFG_WIDTH-1:0] high;
  } chan_cfg_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: shadowed period/high settings loaded at period
// boundaries, registered divided clock and start-of-period tick.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] high,
  output logic             out,
  output logic             tick
);

  chan_state_t      state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] p_s, p_s_nxt;
  logic [WIDTH-1:0] h_s, h_s_nxt;
  logic [WIDTH-1:0] cnt_inc;
  logic             out_nxt, tick_nxt, restart;

  // cnt < p_s while running, so cnt+1 cannot wrap; cnt_inc==p_s is the
  // last-cycle test without ever computing p_s-1 on an idle channel.
  assign cnt_inc = cnt + 1'b1;
  assign restart = sync || (state == CH_IDLE) || (cnt_inc == p_s);

  always_comb begin
    state_nxt = CH_IDLE;
    cnt_nxt   = '0;
    p_s_nxt   = p_s;
    h_s_nxt   = h_s;
    out_nxt   = 1'b0;
    tick_nxt  = 1'b0;
    if (en) begin
      if (restart) begin
        p_s_nxt = period;
        h_s_nxt = high;
        if (period >= WIDTH'(MIN_PERIOD)) begin
          state_nxt = CH_RUN;
          tick_nxt  = 1'b1;
          out_nxt   = (high != '0);
        end
      end else begin
        state_nxt = CH_RUN;
        cnt_nxt   = cnt_inc;
        out_nxt   = (cnt_inc < h_s);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CH_IDLE;
      cnt   <= '0;
      p_s   <= '0;
      h_s   <= '0;
      out   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      p_s   <= p_s_nxt;
      h_s   <= h_s_nxt;
      out   <= out_nxt;
      tick  <= tick_nxt;
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock/tick generator; channel i uses
// bits [i*WIDTH +: WIDTH] of the period and high buses.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*WIDTH-1:0] period,
  input  logic [NCH*WIDTH-1:0] high,
  input  logic                 sync,
  output logic [NCH-1:0]       out,
  output logic [NCH-1:0]       tick
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clkdiv_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .en    (en[i]),
      .sync  (sync),
      .period(period[i*WIDTH +: WIDTH]),
      .high  (high[i*WIDTH +: WIDTH]),
      .out   (out[i]),
      .tick  (tick[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: expected out/tick vectors are queued
// as each cycle's stimulus is driven and compared after the clock edge.
module tb_clkdiv_multi;
  import clkdiv_pkg::*;

  localparam int NCH   = 4;
  localparam int WIDTH = CFG_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       en = '0;
  logic [NCH*WIDTH-1:0] period = '0;
  logic [NCH*WIDTH-1:0] high = '0;
  logic                 sync = 1'b0;
  logic [NCH-1:0]       out, tick;

  typedef struct {
    logic [NCH-1:0] o;
    logic [NCH-1:0] t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clkdiv_multi #(
    .NCH  (NCH),
    .WIDTH(WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .period(period),
    .high  (high),
    .sync  (sync),
    .out   (out),
    .tick  (tick)
  );

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input chan_cfg_t c);
    period[ch*WIDTH +: WIDTH] = c.period;
    high[ch*WIDTH +: WIDTH]   = c.high;
  endtask

  task automatic test_reset();
    exp_t e;
    set_ch(0, '{period: 25'd4, high: 25'd2});
    en = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      e.o = '0; e.t = '0; sb.push_back(e);
      advance();
      e = sb.pop_front(); checks++;
      if (out !== e.o || tick !== e.t) begin
        errors++;
        $display("FAIL reset k=%0d out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.o, e.t);
      end
    end
    en  = '0;
    rst = 1'b0;
    advance();
  endtask

  task automatic test_basic();
    exp_t e;
    set_ch(0, '{period: 25'd4, high: 25'd2});
    en = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      e.o = '0; e.t = '0;
      e.o[0] = (k % 4) < 2;
      e.t[0] = (k % 4) == 0;
      sb.push_back(e);
      advance();
      e = sb.pop_front(); checks++;
      if (out !== e.o || tick !== e.t) begin
        errors++;
        $display("FAIL basic k=%0d out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.o, e.t);
      end
    end
    en = '0;
    advance();
  endtask

  task automatic test_duty();
    exp_t e;
    set_ch(1, '{period: 25'd5, high: 25'd0});
    en = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      e.o = '0; e.t = '0;
      e.o[1] = (k >= 10);
      e.t[1] = (k % 5) == 0;
      sb.push_back(e);
      advance();
      e = sb.pop_front(); checks++;
      if (out !== e.o || tick !== e.t) begin
        errors++;
        $display("FAIL duty k=%0d out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.o, e.t);
      end
      // high changes mid-period; must wait for the boundary at k=10
      if (k == 7) set_ch(1, '{period: 25'd5, high: 25'd7});
    end
    en = '0;
    advance();
  endtask

  task automatic test_reprogram();
    exp_t e;
    int   ph;
    set_ch(0, '{period: 25'd4, high: 25'd2});
    en = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      e.o = '0; e.t = '0;
      if (k < 4) begin
        e.o[0] = k < 2;
        e.t[0] = k == 0;
      end else begin
        ph = (k - 4) % 6;
        e.o[0] = ph < 3;
        e.t[0] = ph == 0;
      end
      sb.push_back(e);
      advance();
      e = sb.pop_front(); checks++;
      if (out !== e.o || tick !== e.t) begin
        errors++;
        $display("FAIL reprogram k=%0d out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.o, e.t);
      end
      if (k == 1) set_ch(0, '{period: 25'd6, high: 25'd3});
    end
    en = '0;
    advance();
  endtask

  task automatic test_sync();
    exp_t e;
    int   p0, p1;
    set_ch(0, '{period: 25'd4, high: 25'd2});
    set_ch(1, '{period: 25'd4, high: 25'd2});
    en = 4'b0001;
    for (int k = 0; k < 15; k++) begin
      if (k < 5) begin
        p0 = k % 4;
        p1 = (k >= 2) ? (k - 2) % 4 : -1;
      end else begin
        p0 = (k - 5) % 4;
        p1 = p0;
      end
      e.o = '0; e.t = '0;
      e.o[0] = p0 < 2;
      e.t[0] = p0 == 0;
      if (p1 >= 0) begin
        e.o[1] = p1 < 2;
        e.t[1] = p1 == 0;
      end
      sb.push_back(e);
      advance();
      e = sb.pop_front(); checks++;
      if (out !== e.o || tick !== e.t) begin
        errors++;
        $display("FAIL sync k=%0d out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.o, e.t);
      end
      if (k == 1) en = 4'b0011;
      // sync at edge 5 truncates; sync at edge 9 coincides with a period end
      sync = (k == 4) || (k == 8);
    end
    en = '0;
    advance();
  endtask

  task automatic test_bad_period();
    exp_t e;
    int   ph;
    set_ch(0, '{period: 25'd1, high: 25'd1});
    en = 4'b0001;
    for (int k = 0; k < 14; k++) begin
      e.o = '0; e.t = '0;
      if (k >= 8) begin
        ph = (k - 8) % 3;
        e.o[0] = ph < 1;
        e.t[0] = ph == 0;
      end
      sb.push_back(e);
      advance();
      e = sb.pop_front(); checks++;
      if (out !== e.o || tick !== e.t) begin
        errors++;
        $display("FAIL bad_period k=%0d out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.o, e.t);
      end
      if (k == 4) set_ch(0, '{period: 25'd0, high: 25'd1});
      if (k == 7) set_ch(0, '{period: 25'd3, high: 25'd1});
    end
    en = '0;
    advance();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    set_ch(0, '{period: 25'd4, high: 25'd3});
    en = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      e.o = '0; e.t = '0;
      e.o[0] = 1'b1;
      e.t[0] = k == 0;
      sb.push_back(e);
      advance();
      e = sb.pop_front(); checks++;
      if (out !== e.o || tick !== e.t) begin
        errors++;
        $display("FAIL mid_run k=%0d out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.o, e.t);
      end
    end
    // async reset at cnt=2 while out is high
    e.o = '0; e.t = '0; sb.push_back(e);
    rst = 1'b1;
    #1;
    e = sb.pop_front(); checks++;
    if (out !== e.o || tick !== e.t) begin
      errors++;
      $display("FAIL rst_async out=%b tick=%b expected out=%b tick=%b", out, tick, e.o, e.t);
    end
    e.o = '0; e.t = '0; sb.push_back(e);
    advance();
    e = sb.pop_front(); checks++;
    if (out !== e.o || tick !== e.t) begin
      errors++;
      $display("FAIL rst_hold out=%b tick=%b expected out=%b tick=%b", out, tick, e.o, e.t);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      e.o = '0; e.t = '0;
      if (k < 3) begin
        e.o[0] = (k % 4) < 3;
        e.t[0] = k == 0;
      end else if (k >= 4) begin
        e.o[0] = ((k - 4) % 4) < 3;
        e.t[0] = k == 4;
      end
      sb.push_back(e);
      advance();
      e = sb.pop_front(); checks++;
      if (out !== e.o || tick !== e.t) begin
        errors++;
        $display("FAIL resume k=%0d out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.o, e.t);
      end
      // drop en at cnt=2 for one edge, then re-enable
      if (k == 2) en = '0;
      if (k == 3) en = 4'b0001;
    end
    en = '0;
    advance();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty();
    test_reprogram();
    test_sync();
    test_bad_period();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
